port_ingress_queue: RTL and testbench

PORT_INGRESS_QUEUE -- requirements
Module: port_ingress_queue

---
 rtl/port_ingress_queue.sv | 217 +++++++++++++++++++++
 tb/tb_port_ingress_queue.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_ingress_queue.sv
// port_ingress_queue
//   Host-side ingress queue for one switch port. Packets offered by the host
//   are filtered (destination must be one-hot and not this port), buffered in
//   a DEPTH-entry FIFO and emitted to the switch port as single-cycle pulses
//   separated by GAP idle cycles. Rejected packets raise drop_pulse.
//
//   Ports
//     clk, rst          clock, asynchronous active-high reset
//     host_valid/ready  host handshake (ready = occupancy below DEPTH)
//     host_target/data  requested one-hot destination and payload
//     sw_valid          one-cycle packet pulse towards the switch port
//     sw_source/target/data  packet fields, zero whenever sw_valid is low
//     drop_pulse        one-cycle flag after a rejected transfer
//     accept_cnt        saturating count of enqueued packets
//     drop_cnt          saturating count of rejected packets
//     fifo_count        current FIFO occupancy
module port_ingress_queue #(
  parameter int unsigned           ADDR_WIDTH = 4,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] SRC_ID     = 4'b0001,
  parameter int unsigned           GAP        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [ADDR_WIDTH-1:0]   host_target,
  input  logic [DATA_WIDTH-1:0]   host_data,
  output logic                    sw_valid,
  output logic [ADDR_WIDTH-1:0]   sw_source,
  output logic [ADDR_WIDTH-1:0]   sw_target,
  output logic [DATA_WIDTH-1:0]   sw_data,
  output logic                    drop_pulse,
  output logic [15:0]             accept_cnt,
  output logic [15:0]             drop_cnt,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [3:0]  GAP_LOAD = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ready_q, ready_d;
  logic [ADDR_WIDTH-1:0] hold_target_q, hold_target_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  sw_valid_q, sw_valid_d;
  logic [ADDR_WIDTH-1:0] sw_source_q, sw_source_d;
  logic [ADDR_WIDTH-1:0] sw_target_q, sw_target_d;
  logic [DATA_WIDTH-1:0] sw_data_q, sw_data_d;
  logic                  drop_q, drop_d;
  logic [15:0]           acc_cnt_q, acc_cnt_d;
  logic [15:0]           drp_cnt_q, drp_cnt_d;

  logic [ADDR_WIDTH-1:0] mem_target [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data   [DEPTH];

  logic legal;
  logic xfer;
  logic push;
  logic pop;

  // Handshake and packet filtering
  always_comb begin
    legal = (host_target != '0)
         && ((host_target & (host_target - ADDR_WIDTH'(1))) == '0)
         && (host_target != SRC_ID);
    xfer  = host_valid && ready_q;
    push  = xfer && legal;
    pop   = (state_q == S_IDLE) && (count_q != '0);
  end

  // FIFO bookkeeping and statistics
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    acc_cnt_d = acc_cnt_q;
    drp_cnt_d = drp_cnt_q;
    drop_d    = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (acc_cnt_q != '1) begin
        acc_cnt_d = acc_cnt_q + 16'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    if (xfer && !legal) begin
      drop_d = 1'b1;
      if (drp_cnt_q != '1) begin
        drp_cnt_d = drp_cnt_q + 16'd1;
      end
    end

    // Ready tracks the occupancy that will be registered, so a pop in the
    // same cycle as a full FIFO only frees a slot from the next cycle on.
    ready_d = (count_d < CNT_W'(DEPTH));
  end

  // Emission FSM. The switch-side fields are registered, so the pulse is
  // visible in the cycle after SEND (accept at k -> pulse at k+2).
  always_comb begin
    state_d       = state_q;
    gap_cnt_d     = gap_cnt_q;
    hold_target_d = hold_target_q;
    hold_data_d   = hold_data_q;
    sw_valid_d    = 1'b0;
    sw_source_d   = '0;
    sw_target_d   = '0;
    sw_data_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          hold_target_d = mem_target[rd_ptr_q];
          hold_data_d   = mem_data[rd_ptr_q];
          state_d       = S_SEND;
        end
      end
      S_SEND: begin
        sw_valid_d  = 1'b1;
        sw_source_d = SRC_ID;
        sw_target_d = hold_target_q;
        sw_data_d   = hold_data_q;
        gap_cnt_d   = GAP_LOAD;
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      gap_cnt_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      hold_target_q <= '0;
      hold_data_q   <= '0;
      sw_valid_q    <= 1'b0;
      sw_source_q   <= '0;
      sw_target_q   <= '0;
      sw_data_q     <= '0;
      drop_q        <= 1'b0;
      acc_cnt_q     <= '0;
      drp_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      hold_target_q <= hold_target_d;
      hold_data_q   <= hold_data_d;
      sw_valid_q    <= sw_valid_d;
      sw_source_q   <= sw_source_d;
      sw_target_q   <= sw_target_d;
      sw_data_q     <= sw_data_d;
      drop_q        <= drop_d;
      acc_cnt_q     <= acc_cnt_d;
      drp_cnt_q     <= drp_cnt_d;
    end
  end

  // Storage array needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_target[wr_ptr_q] <= host_target;
      mem_data[wr_ptr_q]   <= host_data;
    end
  end

  always_comb begin
    host_ready = ready_q;
    sw_valid   = sw_valid_q;
    sw_source  = sw_source_q;
    sw_target  = sw_target_q;
    sw_data    = sw_data_q;
    drop_pulse = drop_q;
    accept_cnt = acc_cnt_q;
    drop_cnt   = drp_cnt_q;
    fifo_count = count_q;
  end

endmodule

// File: tb/tb_port_ingress_queue.sv
module tb_port_ingress_queue;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 1;
  localparam logic [3:0]  SRC   = 4'b0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        host_valid = 1'b0;
  logic [3:0]  host_target = '0;
  logic [7:0]  host_data = '0;
  logic        host_ready;
  logic        sw_valid;
  logic [3:0]  sw_source;
  logic [3:0]  sw_target;
  logic [7:0]  sw_data;
  logic        drop_pulse;
  logic [15:0] accept_cnt;
  logic [15:0] drop_cnt;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  port_ingress_queue #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .SRC_ID(SRC),
    .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .host_valid(host_valid),
    .host_ready(host_ready),
    .host_target(host_target),
    .host_data(host_data),
    .sw_valid(sw_valid),
    .sw_source(sw_source),
    .sw_target(sw_target),
    .sw_data(sw_data),
    .drop_pulse(drop_pulse),
    .accept_cnt(accept_cnt),
    .drop_cnt(drop_cnt),
    .fifo_count(fifo_count)
  );

  // Reference model: each accepted packet gets an emission edge computed
  // arithmetically: max(accept+2, previous emission + GAP + 2).
  typedef struct {
    logic [3:0] tgt;
    logic [7:0] data;
    int         emit;
  } pkt_t;

  typedef struct {
    logic [3:0] tgt;
    logic [7:0] data;
    bit         exp_legal;
  } vec_t;

  pkt_t        q[$];
  int          cyc = 0;
  int          last_emit = -100;
  int          n_total = 0;
  int          n_pass = 0;
  logic        m_ready = 1'b0;
  logic [15:0] m_acc = '0;
  logic [15:0] m_dcnt = '0;
  int          m_count = 0;
  logic        e_valid = 1'b0;
  logic        e_drop = 1'b0;
  logic [3:0]  e_tgt = '0;
  logic [7:0]  e_data = '0;
  bit          last_xfer = 1'b0;
  int          dut_edges[$];
  logic [7:0]  dut_data[$];
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (edge %0d)", name, act, exp, cyc);
  endtask

  function automatic bit is_legal(input logic [3:0] t);
    return ($countones(t) == 1) && (t != SRC);
  endfunction

  task automatic model_reset();
    q.delete();
    last_emit = -100;
    m_ready = 1'b0;
    m_acc = '0;
    m_dcnt = '0;
    m_count = 0;
    e_valid = 1'b0;
    e_drop = 1'b0;
    e_tgt = '0;
    e_data = '0;
  endtask

  task automatic check_outputs();
    chk("sw_valid", sw_valid, e_valid);
    chk("sw_source", sw_source, e_valid ? SRC : 4'b0000);
    chk("sw_target", sw_target, e_tgt);
    chk("sw_data", sw_data, e_data);
    chk("drop_pulse", drop_pulse, e_drop);
    chk("accept_cnt", accept_cnt, m_acc);
    chk("drop_cnt", drop_cnt, m_dcnt);
    chk("fifo_count", fifo_count, m_count);
    chk("host_ready", host_ready, m_ready);
  endtask

  task automatic step();
    int emit;
    int cnt;
    @(posedge clk);
    cyc++;
    e_drop = 1'b0;
    last_xfer = host_valid && m_ready;
    if (last_xfer) begin
      if (is_legal(host_target)) begin
        emit = cyc + 2;
        if (last_emit + int'(GAP) + 2 > emit) emit = last_emit + int'(GAP) + 2;
        q.push_back('{host_target, host_data, emit});
        last_emit = emit;
        if (m_acc != 16'hFFFF) m_acc++;
      end else begin
        e_drop = 1'b1;
        if (m_dcnt != 16'hFFFF) m_dcnt++;
      end
    end
    e_valid = 1'b0;
    e_tgt = '0;
    e_data = '0;
    if (q.size() > 0 && q[0].emit == cyc) begin
      e_valid = 1'b1;
      e_tgt = q[0].tgt;
      e_data = q[0].data;
      void'(q.pop_front());
    end
    cnt = 0;
    foreach (q[i]) if (q[i].emit - 1 > cyc) cnt++;
    m_count = cnt;
    m_ready = (cnt < int'(DEPTH));
    #1;
    check_outputs();
    if (sw_valid === 1'b1) begin
      dut_edges.push_back(cyc);
      dut_data.push_back(sw_data);
    end
  endtask

  task automatic idle(input int n);
    host_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic apply_reset();
    host_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    host_valid = 1'b0;
    while ((q.size() > 0 || m_count > 0) && budget < 500) begin
      step();
      budget++;
    end
    chk("drain_within_budget", budget < 500, 1'b1);
    step();
    step();
  endtask

  // Offers n legal packets with host_valid held; data stays put until taken.
  task automatic feed(input int n, input logic [7:0] base, output bit saw_full);
    int sent = 0;
    int budget = 0;
    logic [3:0] tg;
    saw_full = 1'b0;
    host_valid = 1'b1;
    while (sent < n && budget < 400) begin
      tg = 4'b0010 << (sent % 3);
      host_target = tg;
      host_data = base + 8'(sent);
      step();
      if (last_xfer) sent++;
      if (m_count == int'(DEPTH)) saw_full = 1'b1;
      budget++;
    end
    host_valid = 1'b0;
    chk("feed_within_budget", budget < 400, 1'b1);
  endtask

  task automatic apply_vec(input int i);
    host_valid = 1'b1;
    host_target = vecs[i].tgt;
    host_data = vecs[i].data;
    step();
    host_valid = 1'b0;
    chk("vec_drop_pulse", drop_pulse, !vecs[i].exp_legal);
    step();
    chk("vec_drop_pulse_one_cycle", drop_pulse, 1'b0);
    step();
    chk("vec_emit_valid", sw_valid, vecs[i].exp_legal);
    if (vecs[i].exp_legal) begin
      chk("vec_emit_target", sw_target, vecs[i].tgt);
      chk("vec_emit_data", sw_data, vecs[i].data);
    end
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_full;
    int n0;
    vecs[0] = '{4'b0110, 8'h11, 1'b0};
    vecs[1] = '{4'b0000, 8'h12, 1'b0};
    vecs[2] = '{4'b0001, 8'h13, 1'b0};
    vecs[3] = '{4'b1000, 8'h22, 1'b1};
    vecs[4] = '{4'b0010, 8'h33, 1'b1};
    vecs[5] = '{4'b1111, 8'h44, 1'b0};
    vecs[6] = '{4'b0100, 8'h55, 1'b1};
    vecs[7] = '{4'b0011, 8'h66, 1'b0};

    // Reset state
    apply_reset();
    step();
    chk("ready_after_reset", host_ready, 1'b1);
    idle(2);

    // Single packet latency
    host_valid = 1'b1;
    host_target = 4'b0100;
    host_data = 8'hA5;
    step();
    host_valid = 1'b0;
    chk("single_accept_cnt", accept_cnt, 16'd1);
    step();
    chk("single_no_early_pulse", sw_valid, 1'b0);
    step();
    chk("single_pulse", sw_valid, 1'b1);
    chk("single_source", sw_source, 4'b0001);
    chk("single_target", sw_target, 4'b0100);
    chk("single_data", sw_data, 8'hA5);
    step();
    chk("single_pulse_one_cycle", sw_valid, 1'b0);
    idle(3);

    // Illegal targets, then the rest of the vector table
    n0 = dut_edges.size();
    for (int i = 0; i < 3; i++) apply_vec(i);
    chk("illegal_drop_cnt", drop_cnt, 16'd3);
    chk("illegal_fifo_empty", fifo_count, 3'd0);
    chk("illegal_no_pulse", dut_edges.size() - n0, 0);
    for (int i = 3; i < 8; i++) apply_vec(i);

    // Burst of 6 with host_valid held
    dut_edges.delete();
    dut_data.delete();
    feed(6, 8'h40, saw_full);
    chk("burst_reached_full", saw_full, 1'b1);
    drain();
    chk("burst_pulse_count", dut_edges.size(), 6);
    for (int i = 0; i < dut_data.size(); i++) chk("burst_order", dut_data[i], 8'h40 + 8'(i));
    for (int i = 1; i < dut_edges.size(); i++)
      chk("burst_spacing", dut_edges[i] - dut_edges[i-1], GAP + 2);

    // Wrap-around: 10 packets
    dut_edges.delete();
    dut_data.delete();
    feed(10, 8'h00, saw_full);
    drain();
    chk("wrap_pulse_count", dut_edges.size(), 10);
    for (int i = 0; i < dut_data.size(); i++) chk("wrap_order", dut_data[i], 8'(i));
    chk("wrap_fifo_empty", fifo_count, 3'd0);

    // Reset during GAP with 3 packets queued
    dut_edges.delete();
    dut_data.delete();
    feed(5, 8'h80, saw_full);
    n0 = 0;
    while (dut_edges.size() < 2 && n0 < 20) begin
      step();
      n0++;
    end
    chk("gap_reset_second_pulse_seen", dut_edges.size(), 2);
    chk("gap_reset_queued", fifo_count, 3'd3);
    apply_reset();
    dut_edges.delete();
    step();
    chk("post_reset_ready", host_ready, 1'b1);
    chk("post_reset_fifo", fifo_count, 3'd0);
    idle(8);
    chk("post_reset_no_stale_pulse", dut_edges.size(), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      host_valid = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 3) != 0) host_target = 4'b0001 << $urandom_range(0, 3);
      else host_target = 4'($urandom_range(0, 15));
      host_data = 8'($urandom);
      step();
    end
    drain();

    // Drop counter saturation
    apply_reset();
    step();
    host_valid = 1'b1;
    host_target = 4'b0000;
    repeat (65536) step();
    host_valid = 1'b0;
    step();
    chk("drop_cnt_saturated", drop_cnt, 16'hFFFF);
    chk("accept_cnt_untouched", accept_cnt, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
